// File: rtl/dm_sub.sv
// dm_sub: word-organised data memory for the MIPS datapath.
// Byte/halfword/word loads and stores with sign/zero extension, registered
// read port, range/alignment error pulses, valid/ready request handshake and
// a hardware clear sweep that zeroes every word after reset.
module dm_sub #(
  parameter int unsigned DEPTH_WORDS = 3072,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned IDX_W       = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        we,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        align_err,
  output logic        range_err
);

  localparam logic [2:0] OP_W  = 3'd0;
  localparam logic [2:0] OP_H  = 3'd1;
  localparam logic [2:0] OP_HU = 3'd2;
  localparam logic [2:0] OP_B  = 3'd3;
  localparam logic [2:0] OP_BU = 3'd4;

  typedef enum logic {
    ST_CLEAR,
    ST_IDLE
  } state_e;

  state_e           state;
  logic [IDX_W-1:0] clr_idx;
  logic [31:0]      mem [DEPTH_WORDS];

  logic [31:0]      off;
  logic [1:0]       lane;
  logic             in_range;
  logic             misalign;
  logic             accept;
  logic             do_store;
  logic [IDX_W-1:0] idx;
  logic [31:0]      cur_word;
  logic [31:0]      merged;
  logic [31:0]      load_val;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;

  // The block only takes requests once the clear sweep has finished.
  assign req_ready = (state == ST_IDLE);
  assign accept    = req_valid && req_ready && !reset;

  // Address decode. BASE_ADDR is word-aligned, so the low offset bits equal
  // the byte lane of the raw address.
  assign off      = addr - BASE_ADDR;
  assign lane     = off[1:0];
  assign in_range = (addr >= BASE_ADDR) &&
                    ({2'b00, off[31:2]} < 32'(DEPTH_WORDS));
  // Out-of-range addresses are steered to word 0 so the array is never
  // indexed past its end; such requests neither write nor return data.
  assign idx      = in_range ? off[IDX_W+1:2] : '0;
  assign cur_word = mem[idx];
  assign do_store = accept && we && in_range && !misalign;

  // Alignment rules per access size; unknown op codes count as misaligned.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    misalign = 1'b1;
    case (op)
      OP_W:         misalign = (lane != 2'b00);
      OP_H, OP_HU:  misalign = lane[0];
      OP_B, OP_BU:  misalign = 1'b0;
      default:      misalign = 1'b1;
    endcase
  end

  // Merge store data into the current word; untouched bytes are preserved.
  always_comb begin
    merged = cur_word;
    case (op)
      OP_W: merged = wdata;
      OP_H, OP_HU: begin
        if (lane[1]) merged[31:16] = wdata[15:0];
        else         merged[15:0]  = wdata[15:0];
      end
      OP_B, OP_BU: merged[{lane, 3'b000} +: 8] = wdata[7:0];
      default: merged = cur_word;
    endcase
  end

  // Extract and extend the addressed byte/half/word for a load.
  always_comb begin
    byte_sel = cur_word[{lane, 3'b000} +: 8];
    half_sel = lane[1] ? cur_word[31:16] : cur_word[15:0];
    load_val = cur_word;
    case (op)
      OP_H:    load_val = {{16{half_sel[15]}}, half_sel};
      OP_HU:   load_val = {16'h0000, half_sel};
      OP_B:    load_val = {{24{byte_sel[7]}}, byte_sel};
      OP_BU:   load_val = {24'h000000, byte_sel};
      default: load_val = cur_word;
    endcase
  end

  // Single write port shared by the clear sweep and accepted stores.
  // NOTE: the array itself is not reset; the clear sweep zeroes it one word
  // per cycle, which keeps it mappable onto block RAM.
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) begin
      mem[clr_idx] <= '0;
    end else if (do_store) begin
      mem[idx] <= merged;
    end
  end

  // Sequencer and registered response outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments only.
      state       <= ST_CLEAR;
      clr_idx     <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      align_err   <= 1'b0;
      range_err   <= 1'b0;
    end else begin
      rdata_valid <= 1'b0;
      align_err   <= 1'b0;
      range_err   <= 1'b0;
      if (state == ST_CLEAR) begin
        clr_idx <= clr_idx + IDX_W'(1);
        if (clr_idx == IDX_W'(DEPTH_WORDS - 1)) state <= ST_IDLE;
      end else if (accept) begin
        if (!in_range) begin
          range_err <= 1'b1;
        end else if (misalign) begin
          align_err <= 1'b1;
        end else if (!we) begin
          rdata       <= load_val;
          rdata_valid <= 1'b1;
        end
      end
    end
  end

`ifndef SYNTHESIS
  // Store trace: pc, word-aligned byte address, merged word.
  always_ff @(posedge clk) begin
    if (do_store) $write("@%h: *%h <= %h\n", pc, {addr[31:2], 2'b00}, merged);
  end
`endif

endmodule

// File: doc/dm_sub.md
Name: dm_sub

Overview:
- Parametrised data memory for the single-cycle/pipelined MIPS datapath.
- Successor of the word-only DM. Adds:
  - byte and halfword stores and loads, with sign/zero extension
  - alignment and range error reporting
  - a valid/ready request handshake
  - a registered read port
  - a multi-cycle hardware clear sweep after reset instead of a one-cycle array wipe
- Sits between the ALU/MEM stage and the writeback mux.

Parameters:
- DEPTH_WORDS, 3072, number of 32-bit words stored
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be word-aligned
- IDX_W, 12, width of the internal word index; must satisfy 2^IDX_W >= DEPTH_WORDS

Ports:
- clk  in  1  clock
- reset  in  1  reset
- req_valid  in  1  access request present this cycle
- req_ready  out  1  block can accept a request
- we  in  1  1 = store, 0 = load
- op  in  3  0=W, 1=H, 2=HU, 3=B, 4=BU; 5-7 illegal
- addr  in  32  byte address
- wdata  in  32  store data, right-justified
- pc  in  32  PC of the requesting instruction; used only for the store log
- rdata  out  32  load result, extended
- rdata_valid  out  1  one-cycle pulse when rdata holds a new load result
- align_err  out  1  one-cycle pulse: misaligned access or illegal op
- range_err  out  1  one-cycle pulse: address outside the memory

Behaviour:
- Clock and reset: clock clk; reset reset, synchronous, active-high. All state changes occur on posedge clk.
- Reset sampled high sets:
  - state = CLEAR, clr_idx = 0
  - req_ready = 0, rdata = 0, rdata_valid = 0, align_err = 0, range_err = 0
- State machine:
  - CLEAR: each cycle writes 0 to word clr_idx, then clr_idx += 1. After writing word DEPTH_WORDS-1, the next state is IDLE. The clear takes exactly DEPTH_WORDS cycles after reset deasserts.
  - Reset asserted mid-CLEAR restarts the sweep at index 0.
  - IDLE: req_ready = 1, combinational from state. A request is accepted when req_valid && req_ready.
  - Requests presented while req_ready = 0 are ignored, with no side effects.
- Address decode: off = addr - BASE_ADDR; idx = off[IDX_W+1:2]; lane = addr[1:0].
- Error priority: range first, then align.
  - range_err: addr < BASE_ADDR, or off >> 2 >= DEPTH_WORDS.
  - align_err: W with lane != 0; H/HU with lane[0] = 1; op in 5-7.
  - An erroring request writes nothing and gives rdata_valid = 0. The error flag pulses high for the cycle after acceptance.
- Store (we = 1, no error), memory updated at the accepting edge:
  - W: the whole word is replaced.
  - H: wdata[15:0] goes to bits [31:16] if lane[1], else [15:0].
  - B: wdata[7:0] goes to bits [8*lane+7 : 8*lane].
  - Other bytes of the word are unchanged. HU/BU stores behave as H/B.
  - Simulation log at the accepting edge: "@%h: *%h <= %h". Fields are pc, word-aligned byte address (addr with [1:0] = 0), and the merged 32-bit word after the update.
- Load (we = 0, no error):
  - The word is read at the accepting edge; the extracted/extended value is registered into rdata.
  - rdata_valid = 1 for exactly the following cycle. Latency is 1.
  - Extraction: B/BU take the byte at lane; H/HU take the half at lane[1].
  - B and H are sign-extended; BU and HU are zero-extended.
- rdata holds its last value when no load completes. Errors do not alter rdata.
- Single port, one access per cycle. A load accepted the cycle after a store to the same word returns the updated data; there is no bypass requirement beyond this.
- Back-to-back requests are accepted every cycle in IDLE.

Test Plan:
- Clear sweep: preload garbage, pulse reset for 1 cycle.
  - req_ready stays 0 for exactly 3072 cycles, then rises.
  - A lw from 0x0 and from 0x2FFC both return 0.
- Reset mid-sweep: assert reset at clear cycle 100.
  - req_ready is low for a further 3072 cycles after reset deasserts.
- Word store/load: sw 0x12345678 @0x10, then lw @0x10.
  - rdata = 0x12345678, rdata_valid pulses one cycle after the lw is accepted.
  - Log reads "@<pc>: *00000010 <= 12345678".
- Byte/half merge: sw 0x12345678 @0x20, sb 0xAB @0x21, sh 0xCDEF @0x22.
  - lw @0x20 returns 0xCDEFAB78.
  - lb @0x21 returns 0xFFFFFFAB; lbu @0x21 returns 0x000000AB.
  - lh @0x22 returns 0xFFFFCDEF; lhu @0x22 returns 0x0000CDEF.
- Alignment/illegal op: lw @0x22, sh @0x23, op = 6 @0x0.
  - Each gives an align_err pulse, no rdata_valid, and memory unchanged (a following lw confirms).
- Range: sw @0x3000 and lw @0xFFFF_FFFC.
  - range_err pulses and nothing is written.
  - A range-violating request with a misaligned address reports range_err only.
